// File: rtl/myproject_layernorm_pkg.sv
// Shared types and default geometry for the LayerNorm statistics stage.
package myproject_layernorm_pkg;

  localparam int DEF_N         = 8;
  localparam int DEF_IN_W      = 18;
  localparam int DEF_DIFF_W    = DEF_IN_W + 1;
  localparam int DEF_INV_W     = 12;
  localparam int DEF_LUT_AW    = 10;
  localparam int DEF_VAR_SHIFT = 4;
  localparam int LOG2N         = $clog2(DEF_N);
  localparam int SUM_W         = DEF_IN_W + LOG2N;
  localparam int VAR_W         = 2 * DEF_DIFF_W + LOG2N;

  // inv_std fixed-point scale: rom[a] ~ 2^INV_SCALE_LOG2 / sqrt(a << VAR_SHIFT)
  localparam int INV_SCALE_LOG2 = 13;

  typedef enum logic [2:0] {
    S_LOAD, S_MEAN, S_VAR, S_LUT, S_LUTW, S_EMIT
  } state_t;

  function automatic longint isqrt(input longint v);
    longint r = 0;
    for (int b = 31; b >= 0; b--)
      if ((r + (longint'(1) << b)) * (r + (longint'(1) << b)) <= v) r += longint'(1) << b;
    return r;
  endfunction

  function automatic int inv_sqrt_entry(input int a, input int var_shift, input int w);
    longint r, q, top;
    top = (longint'(1) << w) - 1;
    if (a == 0) return int'(top);
    r = isqrt(longint'(a) << var_shift);
    q = (longint'(1) << INV_SCALE_LOG2) / r;
    if (q > top) q = top;
    if (q < 1) q = 1;
    return int'(q);
  endfunction

endpackage

// File: rtl/myproject_layernorm_stats_if.sv
// Sample-in / difference-out stream bundle of the LayerNorm statistics stage.
interface myproject_layernorm_stats_if #(
  parameter int IN_W   = myproject_layernorm_pkg::DEF_IN_W,
  parameter int DIFF_W = myproject_layernorm_pkg::DEF_DIFF_W,
  parameter int INV_W  = myproject_layernorm_pkg::DEF_INV_W
);
  logic signed [IN_W-1:0]   in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIFF_W-1:0] out_diff;
  logic [INV_W-1:0]         out_inv;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_diff, out_inv, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_diff, out_inv, out_valid
  );
endinterface

// File: rtl/myproject_layernorm_inv_sqrt_rom.sv
// Inverse-sqrt ROM with one-cycle registered read. Contents are generated at elaboration:
// rom[0] saturates, rom[a] = 2^13 / isqrt(a << VAR_SHIFT) clamped to [1, 2^W-1].
module myproject_layernorm_inv_sqrt_rom
  import myproject_layernorm_pkg::*;
#(
  parameter int AW        = DEF_LUT_AW,
  parameter int W         = DEF_INV_W,
  parameter int VAR_SHIFT = DEF_VAR_SHIFT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  q
);
  logic [W-1:0] tbl [2**AW];

  for (genvar a = 0; a < 2**AW; a++) begin : g_tbl
    localparam logic [W-1:0] ENTRY = W'(inv_sqrt_entry(a, VAR_SHIFT, W));
    assign tbl[a] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= tbl[addr];
  end
endmodule

// File: rtl/myproject_layernorm_stats.sv
// LayerNorm statistics: buffer a row, compute mean/variance, look up inv_std, then
// stream (x - mean) with the row's inv_std. Loading and emitting never overlap.
module myproject_layernorm_stats
  import myproject_layernorm_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int IN_W      = DEF_IN_W,
  parameter int DIFF_W    = IN_W + 1,
  parameter int INV_W     = DEF_INV_W,
  parameter int LUT_AW    = DEF_LUT_AW,
  parameter int VAR_SHIFT = DEF_VAR_SHIFT
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  myproject_layernorm_stats_if.slave io,
  output logic                       busy
);
  localparam int L2N       = $clog2(N);
  localparam int ACC_SUM_W = IN_W + L2N;
  localparam int ACC_VAR_W = 2 * DIFF_W + L2N;
  localparam logic [L2N-1:0] LAST = L2N'(N - 1);

  state_t                      state;
  logic [L2N-1:0]              idx, sel;
  logic signed [IN_W-1:0]      row_buf [N];
  logic signed [ACC_SUM_W-1:0] sum;
  logic signed [IN_W-1:0]      mean;
  logic [ACC_VAR_W-1:0]        var_acc, var_sh;
  logic signed [DIFF_W-1:0]    diff;
  logic signed [2*DIFF_W-1:0]  sq;
  logic [LUT_AW-1:0]           lut_addr, rom_addr;
  logic                        accept;

  assign io.in_ready = (state == S_LOAD) && !ap_rst;
  assign accept      = io.in_ready && io.in_valid;

  // One shared subtractor: S_VAR walks idx, S_EMIT preloads the next element.
  assign sel  = (state == S_EMIT) ? idx + 1'b1 : idx;
  assign diff = DIFF_W'(row_buf[sel]) - DIFF_W'(mean);
  assign sq   = diff * diff;

  assign var_sh   = (var_acc >> L2N) >> VAR_SHIFT;
  assign lut_addr = (|var_sh[ACC_VAR_W-1:LUT_AW]) ? '1 : var_sh[LUT_AW-1:0];

  always_ff @(posedge ap_clk) begin
    if (accept) row_buf[idx] <= io.in_data;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= S_LOAD;
      idx          <= '0;
      sum          <= '0;
      var_acc      <= '0;
      mean         <= '0;
      rom_addr     <= '0;
      io.out_valid <= 1'b0;
      io.out_diff  <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (accept) begin
          sum <= sum + ACC_SUM_W'(io.in_data);
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state <= S_MEAN;
            busy  <= 1'b1;
          end
        end
        S_MEAN: begin
          mean  <= IN_W'(sum >>> L2N);
          sum   <= '0;
          state <= S_VAR;
        end
        S_VAR: begin
          var_acc <= var_acc + ACC_VAR_W'($unsigned(sq));
          idx     <= idx + 1'b1;
          if (idx == LAST) state <= S_LUT;
        end
        S_LUT: begin
          rom_addr <= lut_addr;
          var_acc  <= '0;
          state    <= S_LUTW;
        end
        S_LUTW: begin
          io.out_valid <= 1'b1;
          io.out_diff  <= diff;
          state        <= S_EMIT;
        end
        S_EMIT: if (io.out_ready) begin
          if (idx == LAST) begin
            io.out_valid <= 1'b0;
            busy         <= 1'b0;
            idx          <= '0;
            state        <= S_LOAD;
          end else begin
            io.out_diff <= diff;
            idx         <= idx + 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  myproject_layernorm_inv_sqrt_rom #(
    .AW(LUT_AW), .W(INV_W), .VAR_SHIFT(VAR_SHIFT)
  ) u_rom (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .en   (state == S_LUTW),
    .addr (rom_addr),
    .q    (io.out_inv)
  );
endmodule

// File: tb/tb_myproject_layernorm_stats.sv
// Directed bench: row-level reference model plus hand-computed literal expectations.
module tb_myproject_layernorm_stats;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic busy;

  myproject_layernorm_stats_if bus();

  myproject_layernorm_stats dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .io     (bus),
    .busy   (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  int exp_d[$], exp_i[$], got_d[$], got_i[$];
  int last_acc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference inverse std: saturated at zero variance, else 8192/floor(sqrt(16*a)).
  function automatic int model_inv(input int a);
    int r, q;
    if (a == 0) return 4095;
    r = int'($floor($sqrt(real'(16 * a))));
    q = 8192 / r;
    if (q > 4095) q = 4095;
    if (q < 1) q = 1;
    return q;
  endfunction

  task automatic model_row(input int v[8]);
    longint s = 0, va = 0, d;
    int m, a;
    for (int i = 0; i < 8; i++) s += v[i];
    m = (s >= 0) ? int'(s / 8) : -int'((-s + 7) / 8);
    for (int i = 0; i < 8; i++) begin
      d = v[i] - m;
      va += d * d;
      exp_d.push_back(int'(d));
    end
    va = va / 8;
    a = (va / 16 > 1023) ? 1023 : int'(va / 16);
    for (int i = 0; i < 8; i++) exp_i.push_back(model_inv(a));
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && bus.out_valid) begin
      if (exp_d.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        chk("out_diff", int'(bus.out_diff), exp_d[0]);
        chk("out_inv", int'(bus.out_inv), exp_i[0]);
        if (bus.out_ready) begin
          got_d.push_back(int'(bus.out_diff));
          got_i.push_back(int'(bus.out_inv));
          void'(exp_d.pop_front());
          void'(exp_i.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the last accept.
  task automatic send_row(input int v[8]);
    for (int i = 0; i < 8; i++) begin
      int k = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 18'(v[i]);
      @(negedge ap_clk);
      while (!bus.in_ready && k < 100) begin @(negedge ap_clk); k++; end
      if (k >= 100) chk("in_ready_timeout", 0, 1);
      last_acc = cyc;
      @(posedge ap_clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input string name);
    int k = 0;
    while (got_d.size() < n && k < 200) begin @(posedge ap_clk); #1; k++; end
    chk(name, got_d.size(), n);
  endtask

  task automatic run_row(input int v[8], input int ed[8], input int einv, input bit stall);
    int base = got_d.size();
    int k = 0;
    model_row(v);
    send_row(v);
    @(negedge ap_clk);
    while (!bus.out_valid && k < 40) begin @(negedge ap_clk); k++; end
    chk("first_valid_latency", cyc - last_acc, 12);
    chk("busy_in_emit", busy, 1);
    chk("in_ready_in_emit", bus.in_ready, 0);
    if (stall) begin
      wait_outs(base + 3, "pre_stall_count");
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 18'sd999;
      repeat (5) begin
        @(negedge ap_clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_count", got_d.size(), base + 3);
      end
      @(posedge ap_clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
    end
    wait_outs(base + 8, "row_output_count");
    @(negedge ap_clk);
    chk("end_out_valid", bus.out_valid, 0);
    chk("end_in_ready", bus.in_ready, 1);
    chk("end_busy", busy, 0);
    chk("model_queue_drained", exp_d.size(), 0);
    for (int i = 0; i < 8; i++) begin
      if (got_d.size() > base + i) begin
        chk("lit_diff", got_d[base + i], ed[i]);
        chk("lit_inv", got_i[base + i], einv);
      end
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[8], d[8];
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    ap_rst        = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_diff", int'(bus.out_diff), 0);
    chk("rst_out_inv", int'(bus.out_inv), 0);
    chk("rst_busy", busy, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge ap_clk); #1;

    v = '{100, 100, 100, 100, 100, 100, 100, 100};
    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_row(v, d, 4095, 1'b0);

    v = '{4, -4, 4, -4, 4, -4, 4, -4};
    d = '{4, -4, 4, -4, 4, -4, 4, -4};
    run_row(v, d, 2048, 1'b0);

    v = '{-1, 0, 0, 0, 0, 0, 0, 0};
    d = '{0, 1, 1, 1, 1, 1, 1, 1};
    run_row(v, d, 4095, 1'b0);

    v = '{131071, -131072, 131071, -131072, 131071, -131072, 131071, -131072};
    d = '{131072, -131071, 131072, -131071, 131072, -131071, 131072, -131071};
    run_row(v, d, 64, 1'b0);

    v = '{10, 20, 30, 40, 50, 60, 70, 80};
    d = '{-35, -25, -15, -5, 5, 15, 25, 35};
    run_row(v, d, 372, 1'b1);

    // Abort a row in S_VAR: nothing from it may ever be emitted.
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_row(v);
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("abort_rst_in_ready", bus.in_ready, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge ap_clk); #1;

    v = '{100, 100, 100, 100, 100, 100, 100, 100};
    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_row(v, d, 4095, 1'b0);

    repeat (3) @(posedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
